// File: rtl/tick_sched_pkg.sv
// Shared types and default widths for the tick scheduler block.
package tick_sched_pkg;

  localparam int DEF_W  = 6;
  localparam int DEF_RW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/tick_scheduler_if.sv
// Control/status bundle between a tick_scheduler and whatever drives it.
interface tick_scheduler_if
  import tick_sched_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int RW = DEF_RW
) ();

  // start is a one-cycle request taken only in IDLE (period/reps sampled then);
  // stop and pause are levels; tick and done are one-cycle Moore pulses.
  logic          start;
  logic          stop;
  logic          pause;
  logic [W-1:0]  period;
  logic [RW-1:0] reps;
  logic          tick;
  logic          done;
  logic          busy;
  logic [W-1:0]  count;
  logic [RW-1:0] rep_cnt;
  state_e        state;

  modport master (
    output start, stop, pause, period, reps,
    input  tick, done, busy, count, rep_cnt, state
  );

  modport slave (
    input  start, stop, pause, period, reps,
    output tick, done, busy, count, rep_cnt, state
  );

endinterface

// File: rtl/mod_m_tick.sv
// Modulo-P counter: counts 0..P-1 while enabled, flags the P-1 terminal value.
module mod_m_tick #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] period_i,
  output logic [W-1:0] count_o,
  output logic         max_tick_o
);

  logic [W-1:0] count_q, count_d;

  assign max_tick_o = (count_q == (period_i - W'(1)));
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = max_tick_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Periodic tick generator with repetition count, pause and abort control.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int RW = DEF_RW
) (
  input  logic            clk,
  input  logic            reset,
  tick_scheduler_if.slave bus
);

  state_e        state_q, state_d;
  logic [W-1:0]  period_q, period_d;
  logic [RW-1:0] reps_q, reps_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [RW-1:0] rep_inc;
  logic          cnt_en, cnt_clr, max_tick;
  logic [W-1:0]  count_w;

  mod_m_tick #(.W(W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .period_i   (period_q),
    .count_o    (count_w),
    .max_tick_o (max_tick)
  );

  assign rep_inc = rep_q + RW'(1);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    reps_d   = reps_q;
    rep_d    = rep_q;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d  = RUN;
          period_d = (bus.period == '0) ? W'(1) : bus.period;
          reps_d   = bus.reps;
          rep_d    = '0;
          cnt_clr  = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          rep_d   = '0;
          cnt_clr = 1'b1;
        end else if (bus.pause) begin
          state_d = PAUSED;
        end else if (max_tick) begin
          rep_d = rep_inc;
          if ((reps_q != '0) && (rep_inc == reps_q)) begin
            state_d = DONE;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      PAUSED: begin
        if (bus.stop) begin
          state_d = IDLE;
          rep_d   = '0;
          cnt_clr = 1'b1;
        end else if (!bus.pause) begin
          // The resume edge counts as a run cycle, except at the terminal value,
          // which is held so the tick is decoded (and counted) back in RUN.
          state_d = RUN;
          cnt_en  = !max_tick;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (bus.stop) begin
          rep_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      period_q <= W'(1);
      reps_q   <= '0;
      rep_q    <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      reps_q   <= reps_d;
      rep_q    <= rep_d;
    end
  end

  assign bus.tick    = (state_q == RUN) && max_tick;
  assign bus.done    = (state_q == DONE);
  assign bus.busy    = (state_q == RUN) || (state_q == PAUSED);
  assign bus.count   = count_w;
  assign bus.rep_cnt = rep_q;
  assign bus.state   = state_q;

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter W, default 6, counter/period width in bits.
REQ-002 Parameter RW, default 8, repetition-count width in bits.
REQ-003 clk  in  1  single system clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  in  1  single-cycle request to begin a timed sequence.
REQ-006 stop  in  1  abort request; highest priority.
REQ-007 pause  in  1  level; freezes a running sequence while high.
REQ-008 period  in  W  tick period P in cycles; sampled only when start is accepted.
REQ-009 reps  in  RW  ticks before completion; 0 = run continuously; sampled with period.
REQ-010 tick  out  1  one-cycle pulse at each period boundary.
REQ-011 done  out  1  one-cycle pulse when the final repetition completes.
REQ-012 busy  out  1  high in RUN or PAUSED.
REQ-013 count  out  W  current counter value.
REQ-014 rep_cnt  out  RW  ticks issued in the current sequence.

Function
REQ-015 FSM states: IDLE, RUN, PAUSED, DONE; all outputs decoded from registered state, count and rep_cnt (Moore).
REQ-016 IDLE: start=1 and stop=0 -> RUN at next edge; latch period and reps; count=0; rep_cnt=0.
REQ-017 Latched period 0 SHALL be treated as 1.
REQ-018 RUN: count increments by 1 each cycle and wraps to 0 after reaching P-1.
REQ-019 tick = 1 exactly while state==RUN and count==P-1; first tick is the P-th cycle after the start-accept edge; ticks every P cycles thereafter; P=1 -> tick every RUN cycle.
REQ-020 rep_cnt increments on each tick edge, wraps modulo 2^RW when reps=0.
REQ-021 reps!=0: on the tick edge where rep_cnt+1==reps -> DONE; count=0; rep_cnt holds final value.
REQ-022 DONE lasts exactly one cycle with done=1, then IDLE.
REQ-023 RUN with pause=1 -> PAUSED at next edge; count and rep_cnt hold; tick and done suppressed.
REQ-024 PAUSED with pause=0 -> RUN; counting resumes from the held count.
REQ-025 stop=1 in RUN, PAUSED or DONE -> IDLE at next edge; count=0; rep_cnt=0; no done pulse; a tick decoded in that same cycle is still seen but not counted.
REQ-026 start in RUN, PAUSED or DONE is ignored; period/reps changes outside start-accept have no effect.
REQ-027 Priority within one cycle: stop > pause > tick/rep advance > start.
REQ-028 busy = 1 in RUN and PAUSED, 0 in IDLE and DONE.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, count=0, rep_cnt=0, latched period=1, latched reps=0; tick=done=busy=0.
REQ-030 Reset assertion mid-sequence SHALL abort with no done pulse; after deassertion the block waits in IDLE for start.

Structure
REQ-031 Shared package tick_sched_pkg: state enum (IDLE, RUN, PAUSED, DONE), default W and RW.
REQ-032 One sub-module mod_m_tick: W-bit counter with enable, synchronous clear, period input and max-tick output; the FSM drives enable/clear.
REQ-033 RTL SHALL be synthesizable, one clock domain, no latches.

Verification
REQ-034 reset low 20 ns, then start with period=15, reps=0 -> tick at cycles 15, 30, 45 after accept; count wraps 14->0; done never.
REQ-035 period=4, reps=3 -> ticks at cycles 4, 8, 12; done pulse in cycle 13; busy falls with DONE; rep_cnt=3.
REQ-036 period=10, pause high for 5 cycles starting at count=6 -> count held at 6; next tick 5 cycles later than nominal.
REQ-037 stop at count=7 during period=10 run -> IDLE next cycle, count=0, rep_cnt=0, no tick/done; start plus stop in the same IDLE cycle -> stays IDLE.
REQ-038 period=0 and period=1 -> tick high every RUN cycle; reps=2 -> done on cycle 3.
REQ-039 reset asserted mid-run at count=9 -> outputs 0 immediately (asynchronously); a later start restarts from count=0.
